// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM access arbiter: FSM encoding, default
// parameter values and a small counter helper.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_READ    = 2'd2,
        ST_RD_WAIT = 2'd3
    } arb_state_e;

    localparam int unsigned ADDR_W_DEF     = 24;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned STARVE_MAX_DEF = 8;
    localparam int unsigned RD_TIMEOUT_DEF = 255;

    // 16-bit accepted-write counter advance, wrapping 0xFFFF -> 0.
    function automatic logic [15:0] wrap_inc16(input logic [15:0] value);
        return value + 16'd1;
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser for an asynchronous level, followed by a one-cycle
// pulse on each synchronised rising edge.
module sync_rise_detect (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser chain plus one delayed copy for edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/sdram_access_arbiter.sv
// Arbitrates one SDRAM controller port between the I2C write path and the
// display read-back path, with starvation guard, read timeout and FINISH status.
module sdram_access_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned RD_TIMEOUT = RD_TIMEOUT_DEF
) (
    input  logic              MAX10_CLK1_50,
    input  logic              RESET_N,
    input  logic              WR_REQ,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              WR_ACK,
    input  logic              RD_REQ,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic              RD_ACK,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_VALID,
    output logic              RD_ERR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WRITE,
    output logic              MEM_READ,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic              MEM_WAITREQ,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_RDVALID,
    input  logic              FINISH,
    output logic [15:0]       WR_COUNT,
    output logic              WRITE_DONE,
    output logic              BUSY
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int TMO_W    = $clog2(RD_TIMEOUT + 1);

    arb_state_e          state_q,      state_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [DATA_W-1:0]   wdata_q,      wdata_d;
    logic [DATA_W-1:0]   rd_data_q,    rd_data_d;
    logic                mem_write_q,  mem_write_d;
    logic                mem_read_q,   mem_read_d;
    logic                wr_ack_q,     wr_ack_d;
    logic                rd_ack_q,     rd_ack_d;
    logic                rd_valid_q,   rd_valid_d;
    logic                rd_err_q,     rd_err_d;
    logic [15:0]         wr_count_q,   wr_count_d;
    logic                write_done_q, write_done_d;
    logic                busy_q,       busy_d;
    logic [STARVE_W-1:0] starve_q,     starve_d;
    logic [TMO_W-1:0]    tmo_q,        tmo_d;
    logic                finish_rise_s;

    sync_rise_detect u_finish_sync (
        .clk_i   (MAX10_CLK1_50),
        .rst_n_i (RESET_N),
        .async_i (FINISH),
        .rise_o  (finish_rise_s)
    );

    // Next-state and next-output logic for the access sequencer
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_data_d    = rd_data_q;
        mem_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        wr_ack_d     = 1'b0;
        rd_ack_d     = 1'b0;
        rd_valid_d   = 1'b0;
        rd_err_d     = 1'b0;
        wr_count_d   = wr_count_q;
        starve_d     = starve_q;
        tmo_d        = tmo_q;
        write_done_d = write_done_q | finish_rise_s;

        case (state_q)
            ST_IDLE: begin
                // No grant while an ACK is out: the acked REQ is stale, and holding
                // off the other side keeps the write:read ratio at STARVE_MAX:1.
                if (!wr_ack_q && !rd_ack_q && (WR_REQ || RD_REQ)) begin
                    if (RD_REQ && (!WR_REQ || (starve_q == STARVE_W'(STARVE_MAX)))) begin
                        state_d    = ST_READ;
                        addr_d     = RD_ADDR;
                        mem_read_d = 1'b1;
                        starve_d   = '0;
                    end else begin
                        state_d     = ST_WRITE;
                        addr_d      = WR_ADDR;
                        wdata_d     = WR_DATA;
                        mem_write_d = 1'b1;
                        if (RD_REQ && (starve_q != STARVE_W'(STARVE_MAX))) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end else begin
                            starve_d = starve_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (!MEM_WAITREQ) begin
                    wr_ack_d   = 1'b1;
                    wr_count_d = wrap_inc16(wr_count_q);
                    state_d    = ST_IDLE;
                end else begin
                    mem_write_d = 1'b1;
                end
            end
            ST_READ: begin
                if (!MEM_WAITREQ) begin
                    rd_ack_d = 1'b1;
                    tmo_d    = '0;
                    state_d  = ST_RD_WAIT;
                end else begin
                    mem_read_d = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (MEM_RDVALID) begin
                    rd_data_d  = MEM_RDATA;
                    rd_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (tmo_q == TMO_W'(RD_TIMEOUT - 1)) begin
                    rd_err_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge MAX10_CLK1_50) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_data_q    <= '0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            wr_ack_q     <= 1'b0;
            rd_ack_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            wr_count_q   <= 16'd0;
            write_done_q <= 1'b0;
            busy_q       <= 1'b0;
            starve_q     <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            wr_ack_q     <= wr_ack_d;
            rd_ack_q     <= rd_ack_d;
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
            wr_count_q   <= wr_count_d;
            write_done_q <= write_done_d;
            busy_q       <= busy_d;
            starve_q     <= starve_d;
            tmo_q        <= tmo_d;
        end
    end

    assign WR_ACK     = wr_ack_q;
    assign RD_ACK     = rd_ack_q;
    assign RD_DATA    = rd_data_q;
    assign RD_VALID   = rd_valid_q;
    assign RD_ERR     = rd_err_q;
    assign MEM_ADDR   = addr_q;
    assign MEM_WRITE  = mem_write_q;
    assign MEM_READ   = mem_read_q;
    assign MEM_WDATA  = wdata_q;
    assign WR_COUNT   = wr_count_q;
    assign WRITE_DONE = write_done_q;
    assign BUSY       = busy_q;

endmodule
